// File: rtl/rename_unit.sv
// Two-wide register rename stage: RAT lookup, free-list allocation and
// reclamation of physical registers released at retire.
module rename_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_0,
    input  logic [4:0] in_rs1_0,
    input  logic [4:0] in_rs2_0,
    input  logic [4:0] in_rd_0,
    input  logic       in_wr_0,
    input  logic       in_valid_1,
    input  logic [4:0] in_rs1_1,
    input  logic [4:0] in_rs2_1,
    input  logic [4:0] in_rd_1,
    input  logic       in_wr_1,
    input  logic       free_valid_0,
    input  logic [5:0] free_preg_0,
    input  logic       free_valid_1,
    input  logic [5:0] free_preg_1,
    output logic       stall,
    output logic       out_valid_0,
    output logic [5:0] out_prs1_0,
    output logic [5:0] out_prs2_0,
    output logic [5:0] out_prd_0,
    output logic [5:0] out_old_prd_0,
    output logic       out_valid_1,
    output logic [5:0] out_prs1_1,
    output logic [5:0] out_prs2_1,
    output logic [5:0] out_prd_1,
    output logic [5:0] out_old_prd_1,
    output logic [6:0] free_count,
    output logic       free_err
);

    logic [5:0] rat_q [32];
    logic [5:0] fl_q  [64];
    logic [5:0] head_q, tail_q;
    logic [6:0] count_q;
    logic       err_q;

    logic       alloc0, alloc1, accept;
    logic [6:0] need_cnt, pop_cnt, avail, count_d;
    logic [5:0] new0, new1, push1_addr;
    logic       push0_ok, push1_ok, err_set;
    logic [5:0] prs1_0_d, prs2_0_d, prd_0_d, old_0_d;
    logic [5:0] prs1_1_d, prs2_1_d, prd_1_d, old_1_d;

    logic       out_valid_0_q, out_valid_1_q;
    logic [5:0] out_prs1_0_q, out_prs2_0_q, out_prd_0_q, out_old_prd_0_q;
    logic [5:0] out_prs1_1_q, out_prs2_1_q, out_prd_1_q, out_old_prd_1_q;

    // Allocation demand, stall decision, renaming with intra-bundle bypass, free pushes
    always_comb begin
        alloc0   = in_valid_0 & in_wr_0 & (in_rd_0 != 5'd0);
        alloc1   = in_valid_1 & in_wr_1 & (in_rd_1 != 5'd0);
        need_cnt = 7'(alloc0) + 7'(alloc1);
        // Only registered occupancy counts; same-cycle frees never bypass into allocation
        stall    = need_cnt > count_q;
        accept   = ~stall;
        pop_cnt  = accept ? need_cnt : 7'd0;

        new0 = fl_q[head_q];
        new1 = alloc0 ? fl_q[head_q + 6'd1] : fl_q[head_q];

        prs1_0_d = (in_rs1_0 == 5'd0) ? 6'd0 : rat_q[in_rs1_0];
        prs2_0_d = (in_rs2_0 == 5'd0) ? 6'd0 : rat_q[in_rs2_0];
        prd_0_d  = alloc0 ? new0 : 6'd0;
        old_0_d  = alloc0 ? rat_q[in_rd_0] : 6'd0;

        prs1_1_d = (in_rs1_1 == 5'd0) ? 6'd0 :
                   (alloc0 && in_rs1_1 == in_rd_0) ? new0 : rat_q[in_rs1_1];
        prs2_1_d = (in_rs2_1 == 5'd0) ? 6'd0 :
                   (alloc0 && in_rs2_1 == in_rd_0) ? new0 : rat_q[in_rs2_1];
        prd_1_d  = alloc1 ? new1 : 6'd0;
        old_1_d  = !alloc1 ? 6'd0 :
                   (alloc0 && in_rd_1 == in_rd_0) ? new0 : rat_q[in_rd_1];

        // Pushes are checked against the occupancy left after this cycle's pops
        avail      = count_q - pop_cnt;
        push0_ok   = free_valid_0 && (free_preg_0 != 6'd0) && (avail < 7'd64);
        push1_ok   = free_valid_1 && (free_preg_1 != 6'd0) &&
                     ((avail + 7'(push0_ok)) < 7'd64);
        push1_addr = tail_q + 6'(push0_ok);
        err_set    = (free_valid_0 && !push0_ok) || (free_valid_1 && !push1_ok);
        count_d    = avail + 7'(push0_ok) + 7'(push1_ok);
    end

    // RAT update: slot 1 written after slot 0 so it wins on equal rd
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rat_q[i] <= 6'(i);
        end else if (accept) begin
            if (alloc0) rat_q[in_rd_0] <= new0;
            if (alloc1) rat_q[in_rd_1] <= new1;
        end
    end

    // Free-list storage, pointers, occupancy and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) fl_q[i] <= (i < 32) ? 6'(i + 32) : 6'd0;
            head_q  <= 6'd0;
            tail_q  <= 6'd32;
            count_q <= 7'd32;
            err_q   <= 1'b0;
        end else begin
            if (push0_ok) fl_q[tail_q]     <= free_preg_0;
            if (push1_ok) fl_q[push1_addr] <= free_preg_1;
            head_q  <= head_q + pop_cnt[5:0];
            tail_q  <= tail_q + 6'(push0_ok) + 6'(push1_ok);
            count_q <= count_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Registered renamed bundle; a stalled cycle yields an empty bundle
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            out_valid_0_q   <= 1'b0;
            out_prs1_0_q    <= 6'd0;
            out_prs2_0_q    <= 6'd0;
            out_prd_0_q     <= 6'd0;
            out_old_prd_0_q <= 6'd0;
            out_valid_1_q   <= 1'b0;
            out_prs1_1_q    <= 6'd0;
            out_prs2_1_q    <= 6'd0;
            out_prd_1_q     <= 6'd0;
            out_old_prd_1_q <= 6'd0;
        end else begin
            out_valid_0_q   <= in_valid_0;
            out_prs1_0_q    <= in_valid_0 ? prs1_0_d : 6'd0;
            out_prs2_0_q    <= in_valid_0 ? prs2_0_d : 6'd0;
            out_prd_0_q     <= prd_0_d;
            out_old_prd_0_q <= old_0_d;
            out_valid_1_q   <= in_valid_1;
            out_prs1_1_q    <= in_valid_1 ? prs1_1_d : 6'd0;
            out_prs2_1_q    <= in_valid_1 ? prs2_1_d : 6'd0;
            out_prd_1_q     <= prd_1_d;
            out_old_prd_1_q <= old_1_d;
        end
    end

    assign out_valid_0   = out_valid_0_q;
    assign out_prs1_0    = out_prs1_0_q;
    assign out_prs2_0    = out_prs2_0_q;
    assign out_prd_0     = out_prd_0_q;
    assign out_old_prd_0 = out_old_prd_0_q;
    assign out_valid_1   = out_valid_1_q;
    assign out_prs1_1    = out_prs1_1_q;
    assign out_prs2_1    = out_prs2_1_q;
    assign out_prd_1     = out_prd_1_q;
    assign out_old_prd_1 = out_old_prd_1_q;
    assign free_count    = count_q;
    assign free_err      = err_q;

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: sequential-semantics reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rename_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_0, in_wr_0, in_valid_1, in_wr_1;
    logic [4:0] in_rs1_0, in_rs2_0, in_rd_0, in_rs1_1, in_rs2_1, in_rd_1;
    logic       free_valid_0, free_valid_1;
    logic [5:0] free_preg_0, free_preg_1;
    logic       stall, out_valid_0, out_valid_1, free_err;
    logic [5:0] out_prs1_0, out_prs2_0, out_prd_0, out_old_prd_0;
    logic [5:0] out_prs1_1, out_prs2_1, out_prd_1, out_old_prd_1;
    logic [6:0] free_count;

    always #5 clk = ~clk;

    rename_unit dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_rs1_0(in_rs1_0), .in_rs2_0(in_rs2_0),
        .in_rd_0(in_rd_0), .in_wr_0(in_wr_0),
        .in_valid_1(in_valid_1), .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1),
        .in_rd_1(in_rd_1), .in_wr_1(in_wr_1),
        .free_valid_0(free_valid_0), .free_preg_0(free_preg_0),
        .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
        .stall(stall),
        .out_valid_0(out_valid_0), .out_prs1_0(out_prs1_0), .out_prs2_0(out_prs2_0),
        .out_prd_0(out_prd_0), .out_old_prd_0(out_old_prd_0),
        .out_valid_1(out_valid_1), .out_prs1_1(out_prs1_1), .out_prs2_1(out_prs2_1),
        .out_prd_1(out_prd_1), .out_old_prd_1(out_old_prd_1),
        .free_count(free_count), .free_err(free_err)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_stall;

    // Reference model: architectural map, free list as a FIFO queue, sticky error
    logic [5:0] m_rat [32];
    int         m_fl[$];
    bit         m_err;
    int         retire_q[$];
    bit         uniq_en = 1'b0;
    int         total_pops, total_pushes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
        m_fl.delete();
        for (int i = 0; i < 32; i++) m_fl.push_back(32 + i);
        m_err = 1'b0;
        retire_q.delete();
        total_pops = 0;
        total_pushes = 0;
    endtask

    task automatic drive_idle();
        in_valid_0 = 0; in_rs1_0 = 0; in_rs2_0 = 0; in_rd_0 = 0; in_wr_0 = 0;
        in_valid_1 = 0; in_rs1_1 = 0; in_rs2_1 = 0; in_rd_1 = 0; in_wr_1 = 0;
        free_valid_0 = 0; free_preg_0 = 0; free_valid_1 = 0; free_preg_1 = 0;
    endtask

    // Reset with a live request and frees present, which must all be discarded
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid_0 = 1; in_wr_0 = 1; in_rd_0 = 5'd7; in_rs1_0 = 5'd7; in_rs2_0 = 0;
        in_valid_1 = 1; in_wr_1 = 1; in_rd_1 = 5'd8; in_rs1_1 = 0; in_rs2_1 = 0;
        free_valid_0 = 1; free_preg_0 = 6'd0; free_valid_1 = 1; free_preg_1 = 6'd3;
        @(posedge clk); #1;
        model_reset();
        chk("rst_out_valid_0", out_valid_0, 0);
        chk("rst_out_valid_1", out_valid_1, 0);
        chk("rst_out_prd_0", out_prd_0, 0);
        chk("rst_free_count", free_count, 32);
        chk("rst_free_err", free_err, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        chk("rst_stall_idle", stall, 0);
    endtask

    // One cycle: drive bundle + frees, check stall, advance model, check registered outputs
    task automatic step(input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                        input logic [4:0] d0, input logic w0,
                        input logic v1, input logic [4:0] a1, input logic [4:0] b1,
                        input logic [4:0] d1, input logic w1,
                        input logic fv0, input logic [5:0] fp0,
                        input logic fv1, input logic [5:0] fp1);
        logic       vv[2], ww[2], e_val[2], e_alloc[2], o_val[2];
        logic [4:0] ra[2], rb[2], rdd[2];
        logic [5:0] e_p1[2], e_p2[2], e_prd[2], e_old[2];
        logic [5:0] o_p1[2], o_p2[2], o_prd[2], o_old[2];
        logic [5:0] rat_before[32];
        logic       fv[2];
        logic [5:0] fp[2];
        int         need;
        logic       e_stall, found;
        @(negedge clk);
        rst = 1'b0;
        in_valid_0 = v0; in_rs1_0 = a0; in_rs2_0 = b0; in_rd_0 = d0; in_wr_0 = w0;
        in_valid_1 = v1; in_rs1_1 = a1; in_rs2_1 = b1; in_rd_1 = d1; in_wr_1 = w1;
        free_valid_0 = fv0; free_preg_0 = fp0; free_valid_1 = fv1; free_preg_1 = fp1;
        vv[0] = v0; ra[0] = a0; rb[0] = b0; rdd[0] = d0; ww[0] = w0;
        vv[1] = v1; ra[1] = a1; rb[1] = b1; rdd[1] = d1; ww[1] = w1;
        fv[0] = fv0; fp[0] = fp0; fv[1] = fv1; fp[1] = fp1;
        #1;
        need = 0;
        for (int s = 0; s < 2; s++) begin
            e_alloc[s] = vv[s] && ww[s] && (rdd[s] != 5'd0);
            need += int'(e_alloc[s]);
        end
        e_stall = (need > m_fl.size());
        last_stall = stall;
        chk("stall", stall, e_stall);
        for (int i = 0; i < 32; i++) rat_before[i] = m_rat[i];
        // Slots renamed one after the other: slot 1 naturally sees slot 0's mapping
        for (int s = 0; s < 2; s++) begin
            e_val[s] = 0; e_p1[s] = 0; e_p2[s] = 0; e_prd[s] = 0; e_old[s] = 0;
            if (!e_stall && vv[s]) begin
                e_val[s] = 1;
                e_p1[s] = (ra[s] == 0) ? 6'd0 : m_rat[ra[s]];
                e_p2[s] = (rb[s] == 0) ? 6'd0 : m_rat[rb[s]];
                if (e_alloc[s]) begin
                    e_prd[s] = 6'(m_fl.pop_front());
                    e_old[s] = m_rat[rdd[s]];
                    m_rat[rdd[s]] = e_prd[s];
                    retire_q.push_back(int'(e_old[s]));
                    total_pops++;
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (fv[s]) begin
                if (fp[s] == 6'd0 || m_fl.size() >= 64) m_err = 1'b1;
                else begin
                    m_fl.push_back(int'(fp[s]));
                    total_pushes++;
                end
            end
        end
        @(posedge clk); #1;
        o_val[0] = out_valid_0; o_p1[0] = out_prs1_0; o_p2[0] = out_prs2_0;
        o_prd[0] = out_prd_0; o_old[0] = out_old_prd_0;
        o_val[1] = out_valid_1; o_p1[1] = out_prs1_1; o_p2[1] = out_prs2_1;
        o_prd[1] = out_prd_1; o_old[1] = out_old_prd_1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("out_valid_%0d", s), o_val[s], e_val[s]);
            if (e_val[s]) begin
                chk($sformatf("prs1_%0d", s), o_p1[s], e_p1[s]);
                chk($sformatf("prs2_%0d", s), o_p2[s], e_p2[s]);
                if (e_alloc[s] || rdd[s] == 5'd0) begin
                    chk($sformatf("prd_%0d", s), o_prd[s], e_prd[s]);
                    chk($sformatf("old_prd_%0d", s), o_old[s], e_old[s]);
                end
                if (uniq_en && e_alloc[s]) begin
                    found = 0;
                    for (int i = 1; i < 32; i++) if (rat_before[i] == o_prd[s]) found = 1;
                    if (s == 1 && e_alloc[0] && o_prd[1] == o_prd[0]) found = 1;
                    chk($sformatf("unique_prd_%0d", s), found, 0);
                end
            end
        end
        chk("free_count", free_count, m_fl.size());
        chk("free_err", free_err, m_err);
        $display("cyc v=%0d%0d stall=%0d prd=%0d/%0d old=%0d/%0d count=%0d err=%0d",
                 o_val[0], o_val[1], last_stall, o_prd[0], o_prd[1], o_old[0], o_old[1],
                 free_count, free_err);
    endtask

    task automatic idle_free(input logic fv0, input logic [5:0] fp0,
                             input logic fv1, input logic [5:0] fp1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fv0, fp0, fv1, fp1);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        do_reset();

        // Same rd in both slots: chained mapping and bypass
        step(1, 5, 0, 5, 1, 1, 5, 0, 5, 1, 0, 0, 0, 0);
        chk("r25_prd0", out_prd_0, 32);
        chk("r25_old0", out_old_prd_0, 5);
        chk("r25_prs1_0", out_prs1_0, 5);
        chk("r25_prd1", out_prd_1, 33);
        chk("r25_old1", out_old_prd_1, 32);
        chk("r25_prs1_1", out_prs1_1, 32);
        chk("r25_count", free_count, 30);
        step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r25_rat5", out_prs1_0, 33);

        // Drain the free list completely
        for (int k = 0; k < 15; k++)
            step(1, 5'(k), 0, 5'(1 + (2 * k) % 31), 1, 1, 0, 5'(k), 5'(1 + (2 * k + 1) % 31), 1,
                 0, 0, 0, 0);
        chk("r26_count0", free_count, 0);
        step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r26_stall", last_stall, 1);
        chk("r26_valid0", out_valid_0, 0);
        step(1, 1, 2, 0, 1, 1, 3, 4, 7, 0, 0, 0, 0, 0);
        chk("r26_accept_stall", last_stall, 0);
        chk("r26_accept_valid", out_valid_1, 1);
        chk("r26_x0_prd", out_prd_0, 0);

        // A free at empty does not bypass into the same cycle's allocation
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 40, 0, 0);
        chk("r27_stall", last_stall, 1);
        chk("r27_count1", free_count, 1);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r27_prd40", out_prd_0, 40);
        chk("r27_count0", free_count, 0);

        // Two allocations against one free register; concurrent frees help next cycle
        idle_free(1, 43, 0, 0);
        step(1, 0, 0, 10, 1, 1, 0, 0, 11, 1, 1, 41, 1, 42);
        chk("r28_stall", last_stall, 1);
        chk("r28_valid", out_valid_0, 0);
        chk("r28_count3", free_count, 3);
        step(1, 0, 0, 10, 1, 1, 0, 0, 11, 1, 0, 0, 0, 0);
        chk("r28_prd0", out_prd_0, 43);
        chk("r28_prd1", out_prd_1, 41);
        chk("r28_count1", free_count, 1);

        // Protocol errors: free of p0, then overflow past 64
        idle_free(1, 0, 0, 0);
        chk("r29_err_p0", free_err, 1);
        chk("r29_count_p0", free_count, 1);
        do_reset();
        for (int k = 0; k < 16; k++) idle_free(1, 6'(2 * k + 1), 1, 6'(2 * k + 2));
        chk("r29_full", free_count, 64);
        chk("r29_err_clear", free_err, 0);
        idle_free(1, 5, 0, 0);
        chk("r29_err_ovf", free_err, 1);
        chk("r29_count_ovf", free_count, 64);

        // Randomized rename/retire traffic with liveness checks
        do_reset();
        uniq_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic       fv0, fv1;
            logic [5:0] fp0, fp1;
            fv0 = 0; fv1 = 0; fp0 = 0; fp1 = 0;
            if (retire_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                fv0 = 1; fp0 = 6'(retire_q.pop_front());
            end
            if (retire_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                fv1 = 1; fp1 = 6'(retire_q.pop_front());
            end
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                 fv0, fp0, fv1, fp1);
        end
        chk("rand_wrapped", (total_pops >= 64) && (total_pushes >= 32), 1);
        chk("rand_no_err", free_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 The module SHALL provide: clk  in  1  single clock, all state updates on its rising edge.
REQ-002 The module SHALL provide: rst  in  1  reset, synchronous and active-high.
REQ-003 The module SHALL provide, for slot s in {0,1}: in_valid_s  in  1  rename request present.
REQ-004 The module SHALL provide: in_rs1_s, in_rs2_s, in_rd_s  in  5 each  architectural source and destination registers.
REQ-005 The module SHALL provide: in_wr_s  in  1  instruction writes in_rd_s; store and branch requests drive 0.
REQ-006 The module SHALL provide: free_valid_s  in  1, free_preg_s  in  6  physical register released by ROB retire (old destination).
REQ-007 The module SHALL provide: stall  out  1  combinational; bundle not accepted this cycle.
REQ-008 The module SHALL provide: out_valid_s  out  1, out_prs1_s, out_prs2_s, out_prd_s, out_old_prd_s  out  6 each  renamed bundle to ROB and issue.
REQ-009 The module SHALL provide: free_count  out  7  registered free-list occupancy, range 0..64.
REQ-010 The module SHALL provide: free_err  out  1  sticky protocol-error flag.

Function
REQ-011 RAT: 32 entries x 6 bits; free list: 64-entry circular FIFO, 6-bit head and tail pointers, 7-bit count; pointers wrap 63->0.
REQ-012 A slot needs allocation iff in_valid_s & in_wr_s & (in_rd_s != 0); x0 SHALL never be renamed, and its prd/old_prd SHALL be 0.
REQ-013 stall SHALL be 1 iff the number of allocations needed (0..2) exceeds registered free_count; frees arriving in the same cycle SHALL NOT count toward this check.
REQ-014 Bundle is all-or-nothing: with stall=1, no RAT update, no pop, out_valid_0/1 = 0 next cycle; the upstream stage holds its inputs.
REQ-015 Accepted: slot 0 allocates at head, slot 1 at the next entry (or at head if slot 0 does not allocate); head advances by the pop count.
REQ-016 Sources SHALL read RAT; slot 1 rs1/rs2 equal to an allocating slot 0 rd SHALL take slot 0's new prd (intra-bundle bypass); rs = x0 SHALL map to 0.
REQ-017 old_prd = RAT[rd] before the bundle; if slot 1 rd equals an allocating slot 0 rd, slot 1 old_prd SHALL equal slot 0's new prd.
REQ-018 RAT write order: slot 0 then slot 1; for equal rd, slot 1 wins.
REQ-019 Outputs SHALL be registered: latency 1 cycle from an accepted request; out_valid_s = in_valid_s of the accepted bundle.
REQ-020 Frees: each valid free SHALL be pushed at tail (slot 0 first) in the same cycle as any pops; count_next = count - pops + pushes.
REQ-021 A free of preg 0, or a push that would make count exceed 64, SHALL be dropped and SHALL set free_err until reset.
REQ-022 Simultaneous pop and push at count 0 SHALL NOT bypass: a freed register becomes allocatable the next cycle.

Reset
REQ-023 On rst=1 at a clock edge: RAT[i] = i; free-list entries 0..31 = 32..63; head = 0; tail = 32; free_count = 32; free_err = 0; all out_* = 0; stall reflects the reset count.
REQ-024 Reset SHALL override any concurrent request or free in the same cycle; partially accepted bundles SHALL be discarded.

Verification
REQ-025 After reset, slot 0 rd=5, rs1=5, slot 1 rd=5, rs1=5 -> out_prd_0=32, old_prd_0=5, out_prd_1=33, old_prd_1=32, prs1_1=32, RAT[5]=33, free_count=30.
REQ-026 Allocate 32 registers with no frees -> free_count=0; next request with in_wr=1, rd!=0 -> stall=1, out_valid=0; request with rd=0 or in_wr=0 -> accepted.
REQ-027 At free_count=0, free p40 while requesting one allocation -> stall=1 this cycle; next cycle prd=40 is allocated, free_count returns to 0.
REQ-028 With free_count=1 and a two-allocation request -> stall=1, RAT unchanged; the same cycle's two frees make count 3 and accept the bundle next cycle.
REQ-029 Free of p0, or a free at count=64 -> dropped, free_err=1, count unchanged; rst clears free_err.
REQ-030 Cycle allocate/free 100 times -> head and tail wrap past 63, register IDs are never duplicated among live mappings, and count stays consistent.
